// File: rtl/store_port_arbiter_pkg.sv
// Shared store-port types: store micro-op, store ack, slot-table entry and index widths.
package store_port_arbiter_pkg;

    localparam int unsigned ID_W        = 6;
    localparam int unsigned NONCE_W     = 4;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NUM_REQ_MAX = 4;
    localparam int unsigned REQ_IDX_W   = $clog2(NUM_REQ_MAX);

    typedef logic [ID_W-1:0]      StId_t;
    typedef logic [NONCE_W-1:0]   StNonce_t;
    typedef logic [REQ_IDX_W-1:0] ReqIdx_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] wmask;
        StId_t               id;
        StNonce_t            nonce;
        logic                isMMIO;
        logic                valid;
    } ST_UOp;

    typedef struct packed {
        StId_t    idx;
        StNonce_t nonce;
        logic     fail;
        logic     valid;
    } ST_Ack;

    // One in-flight op: who issued it and the tag it must get back.
    typedef struct packed {
        logic     valid;
        ReqIdx_t  req;
        StId_t    id;
        StNonce_t nonce;
        logic     isMMIO;
    } SlotEntry;

endpackage

// File: rtl/store_port_arbiter_if.sv
// Bundle between the store sources, the arbiter and the cache store port.
//   uop[i]    requester i op (held until ready_c[i])
//   ready_c   combinational grant per requester
//   rej[i]    rejection notice back to requester i
//   ack[i]    routed store ack back to requester i
//   uop_st    registered op to the store port (id = slot)
//   stall_st  store port rejected uop_st this cycle
//   st_ack    ack from the store port (idx = slot)
interface store_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import store_port_arbiter_pkg::*;

    ST_UOp              uop [NUM_REQ];
    logic [NUM_REQ-1:0] ready_c;
    ST_Ack              rej [NUM_REQ];
    ST_Ack              ack [NUM_REQ];
    ST_UOp              uop_st;
    logic               stall_st;
    ST_Ack              st_ack;

    modport master (
        input  uop, stall_st, st_ack,
        output ready_c, rej, ack, uop_st
    );

    modport slave (
        output uop, stall_st, st_ack,
        input  ready_c, rej, ack, uop_st
    );

endinterface

// File: rtl/store_port_arbiter_rr_priority_select.sv
// First set bit of req at or after ptr (wrapping), as one-hot grant and index.
//   req    request vector
//   ptr    search start position (must be < N)
//   grant  one-hot winner
//   idx    winner index
//   any    some request was set
module store_port_arbiter_rr_priority_select #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IW'((32'(ptr) + k) % N);
            if (!any && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_port_arbiter.sv
// Round-robin share of the single cache store port between NUM_REQ store sources.
// Ops are re-tagged with an in-flight slot index; rejects and acks are routed back
// to the issuing requester with its original id and nonce.
//   clk, rst  clock, asynchronous active-high reset
//   bus       store_port_arbiter_if master side (requesters + store port)
module store_port_arbiter
    import store_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    store_port_arbiter_if.master   bus
);

    localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    SlotEntry             slot_q [NUM_SLOTS];
    logic [RW-1:0]        rr_ptr_q;
    ST_UOp                uop_st_q;
    ST_Ack                rej_q [NUM_REQ];
    ST_Ack                ack_q [NUM_REQ];

    ST_UOp                uop [NUM_REQ];
    logic [NUM_SLOTS-1:0] slot_free;
    logic                 mmio_busy;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   grant;
    logic [RW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic [NUM_SLOTS-1:0] alloc_oh;
    logic [SW-1:0]        alloc_idx;
    logic                 slot_any;
    ST_UOp                alloc_uop;
    SlotEntry             new_entry;

    logic                 rej_hit;
    logic [SW-1:0]        rej_slot;
    logic                 ack_in_range;
    logic [SW-1:0]        ack_slot;
    logic                 ack_slot_ok;
    logic                 ack_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign uop[i]     = bus.uop[i];
        assign bus.rej[i] = rej_q[i];
        assign bus.ack[i] = ack_q[i];
    end
    assign bus.ready_c = grant;
    assign bus.uop_st  = uop_st_q;

    // Free-slot map and MMIO-in-flight flag, from registered state only.
    always_comb begin
        slot_free = '0;
        mmio_busy = 1'b0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            slot_free[s] = !slot_q[s].valid;
            mmio_busy    = mmio_busy | (slot_q[s].valid & slot_q[s].isMMIO);
        end
    end

    // Lowest free slot: priority search anchored at 0.
    store_port_arbiter_rr_priority_select #(.N(NUM_SLOTS)) u_slot_sel (
        .req   (slot_free),
        .ptr   ('0),
        .grant (alloc_oh),
        .idx   (alloc_idx),
        .any   (slot_any)
    );

    // A second MMIO op waits until the one in flight has retired.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = uop[i].valid & slot_any & ~(uop[i].isMMIO & mmio_busy);
        end
    end

    store_port_arbiter_rr_priority_select #(.N(NUM_REQ)) u_req_sel (
        .req   (elig),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Granted op re-tagged with its slot, plus the slot record that restores the tag.
    always_comb begin
        alloc_uop        = uop[gnt_idx];
        alloc_uop.id     = StId_t'(alloc_idx);
        new_entry        = '0;
        new_entry.valid  = 1'b1;
        new_entry.req    = ReqIdx_t'(gnt_idx);
        new_entry.id     = uop[gnt_idx].id;
        new_entry.nonce  = uop[gnt_idx].nonce;
        new_entry.isMMIO = uop[gnt_idx].isMMIO;
    end

    // Reject targets the op on the port now; an ack colliding with it loses.
    always_comb begin
        rej_hit      = uop_st_q.valid & bus.stall_st;
        rej_slot     = SW'(uop_st_q.id);
        ack_in_range = 32'(bus.st_ack.idx) < NUM_SLOTS;
        ack_slot     = SW'(bus.st_ack.idx);
        ack_slot_ok  = ack_in_range & slot_q[ack_slot].valid;
        ack_hit      = bus.st_ack.valid & ack_slot_ok & ~(rej_hit & (rej_slot == ack_slot));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= '0;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                rej_q[i] <= '0;
                ack_q[i] <= '0;
            end
            rr_ptr_q <= '0;
            uop_st_q <= '0;
        end else begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                if (gnt_any && alloc_oh[s]) begin
                    slot_q[s] <= new_entry;
                end else if ((rej_hit && rej_slot == SW'(s)) || (ack_hit && ack_slot == SW'(s))) begin
                    slot_q[s].valid <= 1'b0;
                end
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                rej_q[i].valid <= rej_hit & (slot_q[rej_slot].req == ReqIdx_t'(i));
                rej_q[i].idx   <= slot_q[rej_slot].id;
                rej_q[i].nonce <= slot_q[rej_slot].nonce;
                rej_q[i].fail  <= 1'b1;
                ack_q[i].valid <= ack_hit & (slot_q[ack_slot].req == ReqIdx_t'(i));
                ack_q[i].idx   <= slot_q[ack_slot].id;
                ack_q[i].nonce <= slot_q[ack_slot].nonce;
                ack_q[i].fail  <= bus.st_ack.fail;
            end
            if (gnt_any) begin
                rr_ptr_q <= (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + RW'(1);
            end
            uop_st_q <= gnt_any ? alloc_uop : '0;
        end
    end

    a_ack_to_valid_slot: assert property (@(posedge clk) disable iff (rst)
        bus.st_ack.valid |-> ack_slot_ok);

    a_no_rej_ack_same_slot: assert property (@(posedge clk) disable iff (rst)
        !(rej_hit && bus.st_ack.valid && ack_in_range && rej_slot == ack_slot));

endmodule

// File: tb/tb_store_port_arbiter.sv
// Scoreboard bench for store_port_arbiter: directed stimulus pushes expected
// store-port ops, rejects and acks; a negedge monitor pops and compares.
module tb_store_port_arbiter;
    import store_port_arbiter_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned NSLOT = 4;

    typedef struct {
        int    req;
        ST_Ack a;
    } resp_t;

    logic clk = 1'b0;
    logic rst;

    store_port_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    store_port_arbiter #(.NUM_REQ(NREQ), .NUM_SLOTS(NSLOT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    ST_UOp exp_st [$];
    resp_t exp_rej [$];
    resp_t exp_ack [$];
    ST_UOp m_op;
    resp_t m_r;

    function automatic ST_UOp mk_uop(input int id, input int nonce, input bit mmio);
        ST_UOp u;
        u        = '0;
        u.valid  = 1'b1;
        u.id     = StId_t'(id);
        u.nonce  = StNonce_t'(nonce);
        u.isMMIO = mmio;
        u.addr   = 32'h4000_0000 + 32'(id) * 32'd8;
        u.data   = 32'hC0DE_0000 + 32'(id * 256 + nonce);
        u.wmask  = 4'(id);
        return u;
    endfunction

    function automatic resp_t mk_resp(input int req, input int id, input int nonce, input bit fail);
        resp_t r;
        r.req     = req;
        r.a.idx   = StId_t'(id);
        r.a.nonce = StNonce_t'(nonce);
        r.a.fail  = fail;
        r.a.valid = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk($sformatf("%s uop_st.valid", name), 64'(bus.uop_st.valid), 64'd0);
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("%s rej[%0d].valid", name, i), 64'(bus.rej[i].valid), 64'd0);
            chk($sformatf("%s ack[%0d].valid", name, i), 64'(bus.ack[i].valid), 64'd0);
        end
    endtask

    task automatic set_req(input int r, input int id, input int nonce, input bit mmio);
        bus.uop[r] = mk_uop(id, nonce, mmio);
    endtask

    task automatic clr_req(input int r);
        bus.uop[r] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the grant vector mid-cycle and queue the op the port must show next cycle.
    task automatic expect_grant(input logic [NREQ-1:0] exp_ready, input int slot, input string name);
        ST_UOp e;
        @(negedge clk);
        chk($sformatf("%s ready", name), 64'(bus.ready_c), 64'(exp_ready));
        for (int r = 0; r < NREQ; r++) begin
            if (exp_ready[r]) begin
                e    = bus.uop[r];
                e.id = StId_t'(slot);
                exp_st.push_back(e);
            end
        end
    endtask

    task automatic ack_cycle(input int slot, input bit fail, input int req, input int oid,
                             input int onon, input string name);
        bus.st_ack.idx   = StId_t'(slot);
        bus.st_ack.nonce = '0;
        bus.st_ack.fail  = fail;
        bus.st_ack.valid = 1'b1;
        exp_ack.push_back(mk_resp(req, oid, onon, fail));
        expect_grant('0, 0, name);
        step();
        bus.st_ack = '0;
    endtask

    // Monitor: every valid DUT output must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.uop_st.valid) begin
                n_cmp++;
                if (exp_st.size() == 0) begin
                    n_err++;
                    $display("FAIL uop_st: unexpected op slot=%0d", bus.uop_st.id);
                end else begin
                    m_op = exp_st.pop_front();
                    if (bus.uop_st !== m_op) begin
                        n_err++;
                        $display("FAIL uop_st: got id=%0d nonce=%0d mmio=%0b addr=%h, expected id=%0d nonce=%0d mmio=%0b addr=%h",
                                 bus.uop_st.id, bus.uop_st.nonce, bus.uop_st.isMMIO, bus.uop_st.addr,
                                 m_op.id, m_op.nonce, m_op.isMMIO, m_op.addr);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.rej[i].valid) begin
                    n_cmp++;
                    if (exp_rej.size() == 0) begin
                        n_err++;
                        $display("FAIL rej[%0d]: unexpected idx=%0d", i, bus.rej[i].idx);
                    end else begin
                        m_r = exp_rej.pop_front();
                        if (m_r.req != i || bus.rej[i] !== m_r.a) begin
                            n_err++;
                            $display("FAIL rej[%0d]: got idx=%0d nonce=%0d fail=%0b, expected req=%0d idx=%0d nonce=%0d fail=%0b",
                                     i, bus.rej[i].idx, bus.rej[i].nonce, bus.rej[i].fail,
                                     m_r.req, m_r.a.idx, m_r.a.nonce, m_r.a.fail);
                        end
                    end
                end
                if (bus.ack[i].valid) begin
                    n_cmp++;
                    if (exp_ack.size() == 0) begin
                        n_err++;
                        $display("FAIL ack[%0d]: unexpected idx=%0d", i, bus.ack[i].idx);
                    end else begin
                        m_r = exp_ack.pop_front();
                        if (m_r.req != i || bus.ack[i] !== m_r.a) begin
                            n_err++;
                            $display("FAIL ack[%0d]: got idx=%0d nonce=%0d fail=%0b, expected req=%0d idx=%0d nonce=%0d fail=%0b",
                                     i, bus.ack[i].idx, bus.ack[i].nonce, bus.ack[i].fail,
                                     m_r.req, m_r.a.idx, m_r.a.nonce, m_r.a.fail);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.uop[0]   = '0;
        bus.uop[1]   = '0;
        bus.st_ack   = '0;
        bus.stall_st = 1'b0;

        // Reset state
        @(negedge clk);
        chk_idle("reset");
        chk("reset ready", 64'(bus.ready_c), 64'd0);
        step();
        step();
        rst = 1'b0;

        // Single requester fills all four slots, then stalls on full
        set_req(0, 7, 1, 0);  expect_grant(2'b01, 0, "fill0"); step();
        set_req(0, 8, 2, 0);  expect_grant(2'b01, 1, "fill1"); step();
        set_req(0, 9, 3, 0);  expect_grant(2'b01, 2, "fill2"); step();
        set_req(0, 10, 4, 0); expect_grant(2'b01, 3, "fill3"); step();
        set_req(0, 11, 5, 0); expect_grant(2'b00, 0, "full");  step();
        // Ack slot 2: no same-cycle reuse, slot 2 granted next cycle
        bus.st_ack = '{idx: StId_t'(2), nonce: '0, fail: 1'b0, valid: 1'b1};
        exp_ack.push_back(mk_resp(0, 9, 3, 0));
        expect_grant(2'b00, 0, "ack no bypass"); step();
        bus.st_ack = '0;
        expect_grant(2'b01, 2, "reuse slot2"); step();
        clr_req(0);
        ack_cycle(0, 0, 0, 7, 1, "drain0");
        ack_cycle(1, 0, 0, 8, 2, "drain1");
        ack_cycle(2, 0, 0, 11, 5, "drain2");
        ack_cycle(3, 0, 0, 10, 4, "drain3");

        // Both requesters valid: alternating grants (pointer currently at 1)
        set_req(0, 20, 0, 0); set_req(1, 30, 1, 0);
        expect_grant(2'b10, 0, "alt0"); step();
        set_req(1, 31, 2, 0);
        expect_grant(2'b01, 1, "alt1"); step();
        set_req(0, 21, 3, 0);
        expect_grant(2'b10, 2, "alt2"); step();
        set_req(1, 32, 4, 0);
        expect_grant(2'b01, 3, "alt3"); step();
        clr_req(0); clr_req(1);
        ack_cycle(0, 0, 1, 30, 1, "alt drain0");
        ack_cycle(1, 0, 0, 20, 0, "alt drain1");
        ack_cycle(2, 0, 1, 31, 2, "alt drain2");
        ack_cycle(3, 0, 0, 21, 3, "alt drain3");

        // Only requester 1 valid: granted every cycle
        set_req(1, 40, 5, 0); expect_grant(2'b10, 0, "solo0"); step();
        set_req(1, 41, 6, 0); expect_grant(2'b10, 1, "solo1"); step();
        set_req(1, 42, 7, 0); expect_grant(2'b10, 2, "solo2"); step();
        clr_req(1);
        ack_cycle(0, 0, 1, 40, 5, "solo drain0");
        ack_cycle(1, 0, 1, 41, 6, "solo drain1");
        ack_cycle(2, 0, 1, 42, 7, "solo drain2");

        // Reject of slot 1 (orig id 5, nonce 3); slot 1 reusable afterwards
        set_req(0, 4, 2, 0); expect_grant(2'b01, 0, "rej pre0"); step();
        set_req(0, 5, 3, 0); expect_grant(2'b01, 1, "rej pre1"); step();
        clr_req(0);
        bus.stall_st = 1'b1;
        exp_rej.push_back(mk_resp(0, 5, 3, 1));
        expect_grant(2'b00, 0, "rej stall"); step();
        bus.stall_st = 1'b0;
        set_req(1, 6, 7, 0); expect_grant(2'b10, 1, "rej reuse"); step();
        clr_req(1);
        ack_cycle(0, 0, 0, 4, 2, "rej drain0");
        ack_cycle(1, 0, 1, 6, 7, "rej drain1");

        // MMIO: second MMIO held until the first acks; non-MMIO passes meanwhile
        set_req(0, 12, 1, 1); expect_grant(2'b01, 0, "mmio0"); step();
        clr_req(0);
        set_req(1, 13, 2, 1); expect_grant(2'b00, 0, "mmio hold0"); step();
        expect_grant(2'b00, 0, "mmio hold1"); step();
        set_req(1, 14, 3, 0); expect_grant(2'b10, 1, "mmio bypass"); step();
        set_req(1, 13, 2, 1);
        bus.st_ack = '{idx: StId_t'(0), nonce: '0, fail: 1'b0, valid: 1'b1};
        exp_ack.push_back(mk_resp(0, 12, 1, 0));
        expect_grant(2'b00, 0, "mmio hold2"); step();
        bus.st_ack = '0;
        expect_grant(2'b10, 0, "mmio release"); step();
        clr_req(1);

        // Fail ack routed with fail=1 and frees the slot
        ack_cycle(1, 1, 1, 14, 3, "fail ack");
        // Reject and ack to different slots in the same cycle
        set_req(0, 15, 4, 0); expect_grant(2'b01, 1, "dual pre"); step();
        clr_req(0);
        bus.stall_st = 1'b1;
        bus.st_ack   = '{idx: StId_t'(0), nonce: '0, fail: 1'b0, valid: 1'b1};
        exp_rej.push_back(mk_resp(0, 15, 4, 1));
        exp_ack.push_back(mk_resp(1, 13, 2, 0));
        expect_grant(2'b00, 0, "dual"); step();
        bus.stall_st = 1'b0;
        bus.st_ack   = '0;
        set_req(0, 16, 5, 0); expect_grant(2'b01, 0, "dual free0"); step();
        set_req(0, 17, 6, 0); expect_grant(2'b01, 1, "dual free1"); step();
        clr_req(0);

        // Third slot in flight, then asynchronous reset while an op is on the port
        set_req(1, 18, 7, 0); expect_grant(2'b10, 2, "pre reset"); step();
        clr_req(1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async reset");
        step();
        chk_idle("reset held");
        rst = 1'b0;
        set_req(0, 21, 1, 0); set_req(1, 22, 2, 0);
        expect_grant(2'b01, 0, "post reset0"); step();
        clr_req(0);
        expect_grant(2'b10, 1, "post reset1"); step();
        clr_req(1);

        for (int k = 0; k < 3; k++) begin
            expect_grant(2'b00, 0, "idle"); step();
        end
        chk("pending uop_st", 64'(exp_st.size()), 64'd0);
        chk("pending rej", 64'(exp_rej.size()), 64'd0);
        chk("pending ack", 64'(exp_ack.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
